// File: rtl/bcd2bin_pkg.sv
// Shared defaults, state encoding and BCD correction constants for the
// sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_SUB       = 4'd3;

endpackage

// File: rtl/bcd_adj3.sv
// Per-nibble correction step of reverse double-dabble: subtract 3 from a
// nibble that reached 8 or more after the right shift.
module bcd_adj3
  import bcd2bin_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // Correct one nibble independently of its neighbours
  always_comb begin
    if (nib_in >= ADJ_THRESH) begin
      nib_out = nib_in - ADJ_SUB;
    end else begin
      nib_out = nib_in;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter: one reverse double-dabble
// iteration per clock, start/done handshake, error flag for digits above 9.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WORK_W = 4*DIGITS + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_t              state_r;
  logic [WORK_W-1:0]   work_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [BIN_W-1:0]    bin_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic [WORK_W-1:0]   shifted_s;
  logic [WORK_W-1:0]   corrected_s;
  logic                bad_digit_s;

  assign shifted_s = work_r >> 1'b1;

  // The binary part passes through; only the BCD nibbles get corrected
  assign corrected_s[BIN_W-1:0] = shifted_s[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .nib_in  (shifted_s[BIN_W + 4*g +: 4]),
      .nib_out (corrected_s[BIN_W + 4*g +: 4])
    );
  end

  // Flag any input digit that is not a legal decimal digit
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_digit_s = bad_digit_s | (bcd[4*i +: 4] > BCD_MAX_DIGIT);
    end
  end

  // Control FSM with registered outputs; bin only moves on done or error
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= IDLE;
      work_r  <= {WORK_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bin_r   <= {BIN_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (bad_digit_s) begin
              bin_r  <= {BIN_W{1'b0}};
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              work_r  <= {bcd, {BIN_W{1'b0}}};
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b1;
              err_r   <= 1'b0;
              state_r <= SHIFT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          work_r <= corrected_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(BIN_W - 1)) begin
            bin_r   <= corrected_s[BIN_W-1:0];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bin  = bin_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: directed scenarios plus randomized sweeps,
// expected results computed from decimal digit arithmetic.
module tb_bcd2bin_seq;

  typedef struct packed {
    logic       err;
    logic [9:0] bin;
  } exp_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic [11:0] bcd = 12'h000;
  logic [9:0]  bin;
  logic        busy, done, err;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  exp_t q[$];
  logic [9:0] prev_bin = 10'd0;

  bcd2bin_seq dut (
    .clk   (clk),
    .res   (res),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_of(input logic [11:0] v);
    exp_t e;
    int   d2, d1, d0;
    d2 = int'(v[11:8]);
    d1 = int'(v[7:4]);
    d0 = int'(v[3:0]);
    e.err = (d2 > 9) || (d1 > 9) || (d0 > 9);
    e.bin = e.err ? 10'd0 : 10'(d2*100 + d1*10 + d0);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [11:0] v);
    q.push_back(exp_of(v));
    exp_done++;
  endtask

  // start pulse that the next rising edge samples
  task automatic pulse(input logic [11:0] v);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
  endtask

  // Monitor: compare each posted result with the scoreboard head
  always @(negedge clk) begin
    if (res) begin
      prev_bin = bin;
    end else begin
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got bin=%0d err=%0d with empty scoreboard", bin, err);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bin", int'(bin), int'(e.bin));
          chk("err", int'(err), int'(e.err));
          if (!e.err) chk("bcd_residue", int'(dut.work_r[21:10]), 0);
        end
      end else begin
        chk("bin_stable", int'(bin), int'(prev_bin));
      end
      prev_bin = bin;
    end
  end

  initial begin
    logic [11:0] v;
    int          gap;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bin", int'(bin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    res = 1'b0;

    // 999: busy for exactly 10 cycles, then done
    @(posedge clk);
    #1;
    push_exp(12'h999);
    pulse(12'h999);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_999", int'(busy), 1);
      chk("nodone_999", int'(done), 0);
    end
    @(negedge clk);
    chk("busy_end_999", int'(busy), 0);
    chk("done_999", int'(done), 1);
    wait_done(exp_done);

    // back-to-back: second start issued during the first done cycle
    @(posedge clk);
    #1;
    push_exp(12'h000);
    pulse(12'h000);
    wait_done(exp_done);
    push_exp(12'h255);
    pulse(12'h255);
    wait_done(exp_done);

    // invalid digit, then a valid value clears err at acceptance
    @(posedge clk);
    #1;
    push_exp(12'h1A3);
    pulse(12'h1A3);
    @(negedge clk);
    chk("err_done_lat1", int'(done), 1);
    chk("err_busy", int'(busy), 0);
    wait_done(exp_done);
    push_exp(12'h042);
    pulse(12'h042);
    @(negedge clk);
    chk("err_cleared", int'(err), 0);
    chk("busy_042", int'(busy), 1);
    wait_done(exp_done);

    // start while busy is ignored
    @(posedge clk);
    #1;
    push_exp(12'h500);
    pulse(12'h500);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    pulse(12'h123);
    wait_done(exp_done);
    repeat (15) @(posedge clk);
    #1;
    chk("single_done_500", done_cnt, exp_done);

    // reset mid-conversion aborts without done
    pulse(12'h777);
    repeat (4) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    @(negedge clk);
    chk("abort_bin", int'(bin), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, exp_done);
    push_exp(12'h010);
    pulse(12'h010);
    wait_done(exp_done);

    // sweep every valid BCD value with random spacing
    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      push_exp(v);
      pulse(v);
      wait_done(exp_done);
    end

    // random raw patterns, many with illegal digits
    for (int n = 0; n < 200; n++) begin
      v = 12'($urandom);
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      push_exp(v);
      pulse(v);
      wait_done(exp_done);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
